// File: rtl/ltssm_pkg.sv
// Shared LTSSM types and default counts for the Polling sequencer.
package ltssm_pkg;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_ACTIVE = 2'd1,
    P_CONFIG = 2'd2
  } polling_st_e;

  typedef enum logic {
    OS_TS1 = 1'b0,
    OS_TS2 = 1'b1
  } os_type_e;

  localparam int POLL_RX_CONSEC  = 8;
  localparam int POLL_TX_TS1_MIN = 1024;
  localparam int POLL_TX_TS2_MIN = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/polling_lane_cnt.sv
// Per-lane saturating ordered-set counter; clear beats increment.
module polling_lane_cnt #(
  parameter int MAX = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] CMAX = W'(MAX);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (inc_i && cnt_q != CMAX) cnt_q <= cnt_q + 1'b1;
  end

  assign sat_o = (cnt_q == CMAX);

endmodule

// File: rtl/control_polling.sv
// LTSSM Polling sub-state sequencer (IDLE -> ACTIVE -> CONFIG).
// Define POLLING_PARTIAL_LANES_EN to fall back to the trained lane subset on ACTIVE timeout.
module control_polling import ltssm_pkg::*; #(
  parameter int NUM_LANES          = 1,
  parameter int RX_CONSEC          = POLL_RX_CONSEC,
  parameter int TX_TS1_MIN         = POLL_TX_TS1_MIN,
  parameter int TX_TS2_MIN         = POLL_TX_TS2_MIN,
  parameter int ACTIVE_TIMEOUT_CYC = 24000,
  parameter int CONFIG_TIMEOUT_CYC = 48000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_LANES-1:0] lanes_detected_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  output logic                 os_tx_req_o,
  output logic                 os_tx_ts2_o,
  input  logic                 os_tx_ack_i,
  output logic [NUM_LANES-1:0] lanes_o,
  output logic                 active_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [1:0]           state_o
);
  localparam int TW = $clog2(max_int(ACTIVE_TIMEOUT_CYC, CONFIG_TIMEOUT_CYC) + 1);
  localparam int XW = $clog2(max_int(TX_TS1_MIN, TX_TS2_MIN) + 1);
  localparam logic [XW-1:0] TX1   = XW'(TX_TS1_MIN);
  localparam logic [XW-1:0] TX2   = XW'(TX_TS2_MIN);
  localparam logic [TW-1:0] TMO_A = TW'(ACTIVE_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_C = TW'(CONFIG_TIMEOUT_CYC - 1);

  polling_st_e          state_q, state_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d;
  logic [NUM_LANES-1:0] lane_inc, lane_clr, lane_sat;
  logic [TW-1:0]        timer_q;
  logic [XW-1:0]        tx_cnt_q, tx_tgt;
  logic                 ts2_seen_q, done_q, to_q, done_d, to_d;
  logic                 all_sat, clr_all, tx_en;

  // Lanes outside the active mask count as satisfied.
  assign all_sat = &(lane_sat | ~lanes_q);
  assign tx_tgt  = (state_q == P_ACTIVE) ? TX1 : TX2;

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      P_IDLE: begin
        if (start_i && !abort_i) begin
          if (|lanes_detected_i) begin
            state_d = P_ACTIVE;
            lanes_d = lanes_detected_i;
          end else begin
            to_d = 1'b1;
          end
        end
      end
      P_ACTIVE: begin
        if (abort_i) begin
          state_d = P_IDLE;
          lanes_d = '0;
        end else if (all_sat && tx_cnt_q == TX1) begin
          state_d = P_CONFIG;
        end else if (timer_q == TMO_A) begin
`ifdef POLLING_PARTIAL_LANES_EN
          if (tx_cnt_q == TX1 && |(lane_sat & lanes_q)) begin
            state_d = P_CONFIG;
            lanes_d = lane_sat & lanes_q;
          end else begin
            state_d = P_IDLE;
            lanes_d = '0;
            to_d    = 1'b1;
          end
`else
          state_d = P_IDLE;
          lanes_d = '0;
          to_d    = 1'b1;
`endif
        end
      end
      P_CONFIG: begin
        if (abort_i) begin
          state_d = P_IDLE;
          lanes_d = '0;
        end else if (all_sat && tx_cnt_q == TX2) begin
          state_d = P_IDLE;
          lanes_d = '0;
          done_d  = 1'b1;
        end else if (timer_q == TMO_C) begin
          state_d = P_IDLE;
          lanes_d = '0;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = P_IDLE;
        lanes_d = '0;
      end
    endcase
  end

  // Any state change restarts every counter; IDLE holds them at zero.
  assign clr_all = (state_d != state_q) || (state_q == P_IDLE);
  assign tx_en   = os_tx_ack_i && tx_cnt_q != tx_tgt &&
                   ((state_q == P_ACTIVE) || (state_q == P_CONFIG && ts2_seen_q));

  always_comb begin
    lane_inc = '0;
    lane_clr = '0;
    if (clr_all) begin
      lane_clr = '1;
    end else if (state_q == P_ACTIVE) begin
      lane_inc = (rx_ts1_i | rx_ts2_i) & lanes_q;
    end else if (state_q == P_CONFIG) begin
      lane_inc = rx_ts2_i & lanes_q;
      lane_clr = rx_ts1_i & lanes_q;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    polling_lane_cnt #(.MAX(RX_CONSEC)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (lane_inc[i]),
      .clr_i  (lane_clr[i]),
      .sat_o  (lane_sat[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= P_IDLE;
      lanes_q    <= '0;
      timer_q    <= '0;
      tx_cnt_q   <= '0;
      ts2_seen_q <= 1'b0;
      done_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      done_q  <= done_d;
      to_q    <= to_d;
      if (clr_all) begin
        timer_q    <= '0;
        tx_cnt_q   <= '0;
        ts2_seen_q <= 1'b0;
      end else begin
        timer_q <= timer_q + 1'b1;
        if (tx_en) tx_cnt_q <= tx_cnt_q + 1'b1;
        if (state_q == P_CONFIG && |(rx_ts2_i & lanes_q)) ts2_seen_q <= 1'b1;
      end
    end
  end

  assign os_tx_req_o = (state_q != P_IDLE);
  assign os_tx_ts2_o = (state_q == P_CONFIG) ? OS_TS2 : OS_TS1;
  assign active_o    = (state_q != P_IDLE);
  assign lanes_o     = lanes_q;
  assign done_o      = done_q;
  assign timeout_o   = to_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_control_polling.sv
// Directed bench for control_polling with a cycle-level behavioural model and literal checkpoints.
module tb_control_polling;
  localparam int NL = 4, RXC = 8, TS1N = 1024, TS2N = 16, ATO = 24000, CTO = 48000;
  localparam int S_IDLE = 0, S_ACT = 1, S_CFG = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, ack = 1'b0;
  logic [NL-1:0] det = '0, ts1 = '0, ts2 = '0;
  logic          req, is_ts2, active, done, tmo;
  logic [NL-1:0] lanes;
  logic [1:0]    state;

  int tests = 0, fails = 0;

  control_polling #(
    .NUM_LANES(NL), .RX_CONSEC(RXC), .TX_TS1_MIN(TS1N), .TX_TS2_MIN(TS2N),
    .ACTIVE_TIMEOUT_CYC(ATO), .CONFIG_TIMEOUT_CYC(CTO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .lanes_detected_i(det), .rx_ts1_i(ts1), .rx_ts2_i(ts2),
    .os_tx_req_o(req), .os_tx_ts2_o(is_ts2), .os_tx_ack_i(ack),
    .lanes_o(lanes), .active_o(active), .done_o(done), .timeout_o(tmo), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the rules of Polling stated directly on integer counts.
  int            m_state = S_IDLE, m_tx = 0, m_timer = 0;
  int            m_rx [NL];
  logic [NL-1:0] m_lanes = '0;
  bit            m_flag = 0, m_done = 0, m_to = 0;

  task automatic m_clear();
    m_tx = 0; m_timer = 0; m_flag = 0;
    for (int i = 0; i < NL; i++) m_rx[i] = 0;
  endtask

  task automatic m_idle();
    m_state = S_IDLE; m_lanes = '0; m_clear();
  endtask

  task automatic model_step();
    int tgt, lim;
    logic [NL-1:0] ok;
    bit partial;
    m_done = 0; m_to = 0;
    if (!rst_n) begin m_idle(); return; end
    if (m_state == S_IDLE) begin
      if (start && !abort) begin
        if (det != 0) begin m_state = S_ACT; m_lanes = det; m_clear(); end
        else m_to = 1;
      end
      return;
    end
    tgt = (m_state == S_ACT) ? TS1N : TS2N;
    lim = (m_state == S_ACT) ? ATO : CTO;
    ok = '0;
    for (int i = 0; i < NL; i++) ok[i] = (m_rx[i] == RXC) && m_lanes[i];
    partial = 0;
`ifdef POLLING_PARTIAL_LANES_EN
    partial = (m_state == S_ACT) && (m_tx == TS1N) && (ok != 0);
`endif
    if (abort) m_idle();
    else if (ok == m_lanes && m_tx == tgt) begin
      if (m_state == S_ACT) begin m_state = S_CFG; m_clear(); end
      else begin m_idle(); m_done = 1; end
    end else if (m_timer == lim - 1) begin
      if (partial) begin m_state = S_CFG; m_lanes = ok; m_clear(); end
      else begin m_idle(); m_to = 1; end
    end else begin
      m_timer++;
      if (ack && (m_state == S_ACT || m_flag) && m_tx < tgt) m_tx++;
      for (int i = 0; i < NL; i++) if (m_lanes[i]) begin
        if (m_state == S_ACT) begin
          if ((ts1[i] || ts2[i]) && m_rx[i] < RXC) m_rx[i]++;
        end else if (ts1[i]) m_rx[i] = 0;
        else if (ts2[i] && m_rx[i] < RXC) m_rx[i]++;
      end
      if (m_state == S_CFG && (ts2 & m_lanes) != 0) m_flag = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) m_rx[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("cycle", {state, lanes, active, req, is_ts2, done, tmo},
        {m_state[1:0], m_lanes, m_state != S_IDLE, m_state != S_IDLE,
         m_state == S_CFG, m_done, m_to});
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic begin_poll(input logic [NL-1:0] mask);
    det = mask; start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; det = '0;
  endtask

  // Runs ACTIVE feeding TS1 on `mask` for the first 8 cycles; returns ACTIVE length.
  task automatic run_active(input logic [NL-1:0] mask, input int budget, output int n);
    n = 0;
    while (state == 2'(S_ACT) && n < budget) begin
      ts1 = (n < RXC) ? mask : '0;
      tick();
      n++;
    end
    ts1 = '0;
    if (n >= budget) chk("active_budget", n, budget - 1);
  endtask

  int n, m;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset_state", {state, lanes, active, req, is_ts2, done, tmo}, 0);

    // 1: two lanes, full success
    begin_poll(4'b0101);
    chk("t1_enter", state, S_ACT);
    run_active(4'b0101, 2000, n);
    chk("t1_active_len", n, 1025);
    chk("t1_in_cfg", state, S_CFG);
    m = 0;
    while (state == 2'(S_CFG) && m < 200) begin
      if (m == 0) chk("t1_lanes", lanes, 4'b0101);
      ts2 = (m < RXC) ? 4'b0101 : '0;
      tick(); m++;
    end
    ts2 = '0;
    chk("t1_cfg_len", m, 18);
    chk("t1_done", done, 1);
    ack = 1'b0; tick();
    chk("t1_done_once", done, 0);

    // 3: TS1 (with simultaneous TS2) mid-CONFIG clears lane count
    begin_poll(4'b0001);
    run_active(4'b0001, 2000, n);
    m = 0;
    while (state == 2'(S_CFG) && m < 200) begin
      ts2 = (m < 6 || (m >= 20 && m < 28)) ? 4'b0001 : '0;
      ts1 = (m == 5) ? 4'b0001 : '0;
      tick(); m++;
    end
    ts1 = '0; ts2 = '0;
    chk("t3_cfg_len", m, 29);
    chk("t3_done", done, 1);

    // 4: abort in the success cycle
    begin_poll(4'b0001);
    run_active(4'b0001, 2000, n);
    m = 0;
    while (state == 2'(S_CFG) && m < 200) begin
      ts2 = (m < RXC) ? 4'b0001 : '0;
      abort = (m == 17);
      tick(); m++;
    end
    ts2 = '0; abort = 1'b0;
    chk("t4_cfg_len", m, 18);
    chk("t4_no_done", done, 0);
    chk("t4_lanes_clr", lanes, 0);

    // 6: start re-pulsed in ACTIVE is ignored
    begin_poll(4'b0001);
    n = 0;
    while (state == 2'(S_ACT) && n < 2000) begin
      ts1 = (n < RXC) ? 4'b0001 : '0;
      start = (n == 100); det = (n == 100) ? 4'b1111 : '0;
      tick(); n++;
    end
    ts1 = '0; start = 1'b0; det = '0;
    chk("t6_active_len", n, 1025);
    chk("t6_lanes", lanes, 4'b0001);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_abort", state, S_IDLE);

    // 5: zero mask, then async reset mid-ACTIVE
    ack = 1'b0;
    begin_poll(4'b0000);
    chk("t5_zero_to", tmo, 1);
    chk("t5_zero_inactive", active, 0);
    tick();
    chk("t5_to_once", tmo, 0);
    begin_poll(4'b0011);
    repeat (5) tick();
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", {state, lanes, active, req, is_ts2, done, tmo}, 0);
    tick(); rst_n = 1'b1; ack = 1'b0; tick();

    // 2: lane 2 gets only 7 TS1 -> ACTIVE timeout
    begin_poll(4'b0101);
    n = 0;
    while (state == 2'(S_ACT) && n < ATO + 100) begin
      ts1 = (n < 7) ? 4'b0101 : (n == 7) ? 4'b0001 : '0;
      tick(); n++;
    end
    ts1 = '0;
    chk("t2_active_len", n, ATO);
`ifdef POLLING_PARTIAL_LANES_EN
    chk("t2_state", state, S_CFG);
    chk("t2_lanes", lanes, 4'b0001);
    chk("t2_no_to", tmo, 0);
    abort = 1'b1; tick(); abort = 1'b0;
`else
    chk("t2_state", state, S_IDLE);
    chk("t2_to", tmo, 1);
`endif
    ack = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_polling.md
Name: control_polling

Overview:
- Polling sub-state sequencer for the LTSSM controller.
- Entered when the top-level controller moves DETECT->POLLING. It gates TS1/TS2 ordered-set transmission on the lanes that detected a receiver. It counts received ordered sets per lane and sent ordered sets.
- Reports success (advance to CONFIGURATION) or timeout (return to DETECT) to the controller.
- Sits beside control_detect; drives the ordered-set transmit scheduler in front of the 8b/10b encoder.

Parameters:
NUM_LANES, 1, number of link lanes
RX_CONSEC, 8, consecutive matching ordered sets required per lane
TX_TS1_MIN, 1024, TS1s that must be sent in ACTIVE before exit
TX_TS2_MIN, 16, TS2s that must be sent in CONFIG after first TS2 received
ACTIVE_TIMEOUT_CYC, 24000, ACTIVE timeout in clk_i cycles
CONFIG_TIMEOUT_CYC, 48000, CONFIG timeout in clk_i cycles

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse: begin Polling
abort_i  in  1  force return to IDLE
lanes_detected_i  in  NUM_LANES  lane mask latched from Detect; sampled on accepted start_i
rx_ts1_i  in  NUM_LANES  per-lane pulse: one TS1 received
rx_ts2_i  in  NUM_LANES  per-lane pulse: one TS2 received
os_tx_req_o  out  1  request ordered-set transmission on lanes_o
os_tx_ts2_o  out  1  0=TS1, 1=TS2
os_tx_ack_i  in  1  one ordered set sent on all lanes_o (lockstep)
lanes_o  out  NUM_LANES  active lane mask
active_o  out  1  block busy (ACTIVE or CONFIG)
done_o  out  1  one-cycle pulse: Polling succeeded
timeout_o  out  1  one-cycle pulse: Polling failed
state_o  out  2  current polling_st_e

Behaviour:
- Reset: state IDLE. All outputs 0. All counters 0.
- States: IDLE, ACTIVE, CONFIG.
- IDLE:
  - start_i with lanes_detected_i != 0 -> ACTIVE next cycle; latch lanes_o.
  - start_i with zero mask -> timeout_o pulse next cycle; stay IDLE.
- ACTIVE:
  - os_tx_req_o=1, os_tx_ts2_o=0.
  - Each os_tx_ack_i increments tx_cnt, saturating at TX_TS1_MIN.
  - Per lane in lanes_o: rx_ts1_i or rx_ts2_i increments that lane's rx_cnt, saturating at RX_CONSEC. Lanes outside lanes_o are ignored.
  - Exit when all lanes_o lanes have rx_cnt==RX_CONSEC and tx_cnt==TX_TS1_MIN -> CONFIG. Clear tx_cnt, rx_cnt and timer on entry.
  - timer reaching ACTIVE_TIMEOUT_CYC-1 without exit -> IDLE with timeout_o pulse.
- CONFIG:
  - os_tx_req_o=1, os_tx_ts2_o=1.
  - rx_ts2_i increments the lane's rx_cnt (saturating); rx_ts1_i on a lane clears it.
  - rx_ts1_i and rx_ts2_i in the same cycle on one lane: clear wins.
  - tx_cnt counts acks only after the first rx_ts2_i on any active lane (sticky flag).
  - Exit when all lanes_o have rx_cnt==RX_CONSEC and tx_cnt==TX_TS2_MIN -> IDLE with done_o pulse.
  - timer reaching CONFIG_TIMEOUT_CYC-1 -> IDLE with timeout_o pulse.
- Latency: exit condition true in cycle N -> state change and done_o/timeout_o registered in cycle N+1.
- Priority when simultaneous: abort_i > success > timeout. An ack in the exit cycle counts for the old state, then the counter is cleared.
- abort_i:
  - Any state -> IDLE next cycle; no done_o or timeout_o.
  - Counters, flag and lanes_o cleared.
  - start_i in the same cycle as abort_i is ignored.
- start_i while ACTIVE/CONFIG is ignored.
- os_tx_req_o drops in the cycle the state returns to IDLE; an ack arriving in IDLE is ignored.
- Reset mid-operation: immediate return to reset values, no pulses.
- Timer width: $clog2(max(ACTIVE_TIMEOUT_CYC, CONFIG_TIMEOUT_CYC)+1). It never wraps.
- lanes_o is held constant throughout ACTIVE and CONFIG unless the optional feature below changes it.

Optional Feature:
- POLLING_PARTIAL_LANES_EN defined:
  - On ACTIVE timeout, if tx_cnt==TX_TS1_MIN and a nonzero subset of lanes_o has rx_cnt==RX_CONSEC, go to CONFIG instead of failing.
  - lanes_o is narrowed to that subset in the same transition; no timeout_o is pulsed.
- Not defined: ACTIVE timeout always fails, as described above.

Decomposition:
- ltssm_pkg gains:
  - polling_st_e {P_IDLE, P_ACTIVE, P_CONFIG}, 2 bits;
  - os_type_e {OS_TS1, OS_TS2};
  - default count constants (RX_CONSEC, TX_TS1_MIN, TX_TS2_MIN).
- One sub-module, polling_lane_cnt: per-lane saturating counter with inc/clr/sat inputs, width $clog2(RX_CONSEC+1). Instantiated NUM_LANES times via generate.

Test Plan:
1. NUM_LANES=4, mask 4'b0101. start_i, ack every cycle, 8 TS1 on lanes 0 and 2, then 8 TS2 on both -> CONFIG after 1024 acks. done_o pulses after 16 post-TS2 acks; lanes_o=4'b0101 throughout.
2. ACTIVE with lane 2 receiving only 7 TS1 -> timeout_o pulse at cycle 24000 after entry; state IDLE. With POLLING_PARTIAL_LANES_EN -> CONFIG with lanes_o=4'b0001, no timeout_o.
3. CONFIG: lane 0 receives 5 TS2, then 1 TS1, then 8 TS2 -> done_o only after the 8 TS2 following the TS1 (counter cleared).
4. abort_i asserted in the same cycle the CONFIG success condition becomes true -> IDLE next cycle, no done_o.
5. start_i with lanes_detected_i=0 -> timeout_o pulse next cycle, active_o stays 0. rst_ni low mid-ACTIVE -> all outputs 0 asynchronously.
6. start_i re-pulsed during ACTIVE -> ignored; tx_cnt and timer continue uninterrupted.
